// File: rtl/ahb_burst_master.sv
// ahb_burst_master: command-driven AHB-Lite master issuing SINGLE, INCR, INCRx and WRAPx bursts,
// fully pipelined with one beat per cycle when the bus is ready.
// Define AHB_MASTER_STATS_EN to add the beat_cnt / err_cnt statistics outputs.
`timescale 1ns/1ps
module ahb_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_burst,
    input  logic [2:0]        cmd_size,
    output logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
`ifdef AHB_MASTER_STATS_EN
    output logic [15:0]       beat_cnt,
    output logic [7:0]        err_cnt,
`endif
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hreadyin,
    input  logic              hresp
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [2:0] MAX_SIZE     = 3'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        LAST,
        ERR
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [1:0]        htrans_q, htrans_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [2:0]        hburst_q, hburst_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [DATA_W-1:0] rdData_q, rdData_d;
    logic              rdValid_q, rdValid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cmdReady_q, cmdReady_d;
    logic [3:0]        beatsLeft_q, beatsLeft_d;
    logic              wrReq;

    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wrapMask;
    logic [ADDR_W-1:0] sumAddr;
    logic [ADDR_W-1:0] nextAddr;
    logic              isWrap;
    logic              dataPhase;

    // Number of beats in a burst; SINGLE and undefined-length INCR both issue one beat
    function automatic logic [4:0] burstBeats(input logic [2:0] burst);
        case (burst)
            3'b010, 3'b011: burstBeats = 5'd4;
            3'b100, 3'b101: burstBeats = 5'd8;
            3'b110, 3'b111: burstBeats = 5'd16;
            default:        burstBeats = 5'd1;
        endcase
    endfunction

    // WRAP bursts keep the upper address bits of an aligned (beats x bytes) block
    assign incr      = ADDR_W'(1) << hsize_q;
    assign wrapMask  = (ADDR_W'(burstBeats(hburst_q)) << hsize_q) - ADDR_W'(1);
    assign sumAddr   = haddr_q + incr;
    assign isWrap    = (hburst_q != 3'b000) && !hburst_q[0];
    assign nextAddr  = isWrap ? ((haddr_q & ~wrapMask) | (sumAddr & wrapMask)) : sumAddr;

    // A data phase is outstanding whenever a SEQ beat is in address phase, or in the final data-only cycle
    assign dataPhase = ((state_q == ADDR) && (htrans_q == TRANS_SEQ)) || (state_q == LAST);

    // Next-state and bus-output logic; a low hreadyin freezes everything except an error abort
    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hburst_d    = hburst_q;
        hwdata_d    = hwdata_q;
        rdData_d    = rdData_q;
        beatsLeft_d = beatsLeft_q;
        rdValid_d   = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        wrReq       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmdReady_q) begin
                    if (cmd_size > MAX_SIZE) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d     = ADDR;
                        haddr_d     = cmd_addr;
                        htrans_d    = TRANS_NONSEQ;
                        hwrite_d    = cmd_write;
                        hsize_d     = cmd_size;
                        hburst_d    = cmd_burst;
                        beatsLeft_d = 4'(burstBeats(cmd_burst) - 5'd1);
                    end
                end
            end

            ADDR, LAST: begin
                if (dataPhase && hresp) begin
                    htrans_d = TRANS_IDLE;
                    if (hreadyin) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        if (!hwrite_q) begin
                            rdValid_d = 1'b1;
                            rdData_d  = hrdata;
                        end
                    end else begin
                        state_d = ERR;
                    end
                end else if (hreadyin) begin
                    if (dataPhase && !hwrite_q) begin
                        rdValid_d = 1'b1;
                        rdData_d  = hrdata;
                    end
                    if (state_q == ADDR) begin
                        wrReq = hwrite_q;
                        if (hwrite_q) begin
                            hwdata_d = wr_data;
                        end
                        if (beatsLeft_q == 4'd0) begin
                            state_d  = LAST;
                            htrans_d = TRANS_IDLE;
                        end else begin
                            haddr_d     = nextAddr;
                            htrans_d    = TRANS_SEQ;
                            beatsLeft_d = beatsLeft_q - 4'd1;
                        end
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            ERR: begin
                if (hreadyin) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    if (!hwrite_q) begin
                        rdValid_d = 1'b1;
                        rdData_d  = hrdata;
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                htrans_d = TRANS_IDLE;
            end
        endcase

        cmdReady_d = (state_d == IDLE);
    end

    // State and output registers, cleared asynchronously so a reset aborts any burst silently
    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= IDLE;
            haddr_q     <= '0;
            htrans_q    <= TRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'd0;
            hburst_q    <= 3'd0;
            hwdata_q    <= '0;
            rdData_q    <= '0;
            rdValid_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmdReady_q  <= 1'b0;
            beatsLeft_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hburst_q    <= hburst_d;
            hwdata_q    <= hwdata_d;
            rdData_q    <= rdData_d;
            rdValid_q   <= rdValid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cmdReady_q  <= cmdReady_d;
            beatsLeft_q <= beatsLeft_d;
        end
    end

`ifdef AHB_MASTER_STATS_EN
    logic [15:0] beatCnt_q;
    logic [7:0]  errCnt_q;
    logic        beatDone;

    assign beatDone = hreadyin && (dataPhase || (state_q == ERR));

    // Saturating counters of completed data beats and of commands that ended with an error
    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            beatCnt_q <= 16'd0;
            errCnt_q  <= 8'd0;
        end else begin
            if (beatDone && (beatCnt_q != 16'hFFFF)) begin
                beatCnt_q <= beatCnt_q + 16'd1;
            end
            if (err_d && (errCnt_q != 8'hFF)) begin
                errCnt_q <= errCnt_q + 8'd1;
            end
        end
    end

    assign beat_cnt = beatCnt_q;
    assign err_cnt  = errCnt_q;
`endif

    assign cmd_ready = cmdReady_q;
    assign wr_req    = wrReq;
    assign rd_valid  = rdValid_q;
    assign rd_data   = rdData_q;
    assign done      = done_q;
    assign err       = err_q;
    assign haddr     = haddr_q;
    assign htrans    = htrans_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hburst    = hburst_q;
    assign hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// tb_ahb_burst_master: directed bench for ahb_burst_master with a small AHB slave and bus monitor.
// Read data returned by the slave is the data-phase address XOR 0x5A5A_0000 unless a fixed value is selected.
`timescale 1ns/1ps
module tb_ahb_burst_master;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic        clk      = 1'b0;
    logic        hresetn  = 1'b0;
    logic        cmdValid = 1'b0;
    logic        cmdWrite = 1'b0;
    logic [31:0] cmdAddr  = 32'd0;
    logic [2:0]  cmdBurst = 3'd0;
    logic [2:0]  cmdSize  = 3'd0;
    logic        hreadyin = 1'b1;
    logic        hresp    = 1'b0;
    logic        cmdReady, wrReq, rdValid, done, err, hwrite;
    logic [31:0] wrData, rdData, haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
`ifdef AHB_MASTER_STATS_EN
    logic [15:0] beatCnt;
    logic [7:0]  errCnt;
`endif

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [31:0] addrLog[$];
    logic [1:0]  transLog[$];
    logic [31:0] wdLog[$];
    logic [31:0] rdLog[$];
    int wrReqCnt, doneCnt, errPulses, busyCnt, tHs, tDone, tFirstRd;

    logic        dpActive = 1'b0;
    logic        dpWrite  = 1'b0;
    logic [31:0] dpAddr   = 32'd0;
    logic [31:0] wrBase   = 32'd0;
    int          wrIdx    = 0;
    logic        useFixed = 1'b0;
    logic [31:0] fixedRd  = 32'd0;

    logic [31:0] snapAddr[0:63];
    logic [1:0]  snapTrans[0:63];
    logic [31:0] snapWd[0:63];

    assign wrData = wrBase + 32'(wrIdx);
    assign hrdata = useFixed ? fixedRd : (dpAddr ^ 32'h5A5A_0000);

    ahb_burst_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .hresetn  (hresetn),
        .cmd_valid(cmdValid),
        .cmd_ready(cmdReady),
        .cmd_write(cmdWrite),
        .cmd_addr (cmdAddr),
        .cmd_burst(cmdBurst),
        .cmd_size (cmdSize),
        .wr_req   (wrReq),
        .wr_data  (wrData),
        .rd_valid (rdValid),
        .rd_data  (rdData),
        .done     (done),
        .err      (err),
`ifdef AHB_MASTER_STATS_EN
        .beat_cnt (beatCnt),
        .err_cnt  (errCnt),
`endif
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hburst   (hburst),
        .hwdata   (hwdata),
        .hrdata   (hrdata),
        .hreadyin (hreadyin),
        .hresp    (hresp)
    );

    // Free-running bus clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus cycle: sample at negedge, let the edge happen, then update slave/data-source state
    task automatic tick();
        logic        nValid, nWrite, rdy, consumed;
        logic [31:0] nAddr;
        int          kk;
        @(negedge clk);
        if (cmdValid && cmdReady) tHs = cyc;
        if (htrans == 2'b01) busyCnt++;
        if (htrans[1] && hreadyin) begin
            addrLog.push_back(haddr);
            transLog.push_back(htrans);
        end
        if (dpActive && dpWrite && hreadyin) wdLog.push_back(hwdata);
        if (rdValid) begin
            rdLog.push_back(rdData);
            if (tFirstRd < 0) tFirstRd = cyc;
        end
        if (wrReq) wrReqCnt++;
        if (done) begin
            doneCnt++;
            tDone = cyc;
            if (err) errPulses++;
        end
        kk = cyc - tHs;
        if (tHs >= 0 && kk >= 0 && kk < 64) begin
            snapAddr[6'(kk)]  = haddr;
            snapTrans[6'(kk)] = htrans;
            snapWd[6'(kk)]    = hwdata;
        end
        nValid   = htrans[1] && hreadyin;
        nAddr    = haddr;
        nWrite   = hwrite;
        rdy      = hreadyin;
        consumed = wrReq;
        @(posedge clk);
        cyc++;
        #1;
        if (rdy) begin
            dpActive = nValid;
            dpAddr   = nAddr;
            dpWrite  = nWrite;
        end
        if (consumed) wrIdx++;
        if (!hresetn) dpActive = 1'b0;
    endtask

    task automatic issueCmd(input logic w, input logic [31:0] a, input logic [2:0] b, input logic [2:0] s);
        addrLog.delete();
        transLog.delete();
        wdLog.delete();
        rdLog.delete();
        wrReqCnt  = 0;
        doneCnt   = 0;
        errPulses = 0;
        tHs       = -1;
        tDone     = -1;
        tFirstRd  = -1;
        wrIdx     = 0;
        cmdValid  = 1'b1;
        cmdWrite  = w;
        cmdAddr   = a;
        cmdBurst  = b;
        cmdSize   = s;
        for (int k = 0; k < 20 && tHs < 0; k++) tick();
        cmdValid = 1'b0;
        if (tHs < 0) checkOutput("handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [2:0] b, input logic [2:0] s,
                                 input int stallK, input int stallLen, input int errK);
        issueCmd(w, a, b, s);
        for (int k = 1; k < 70 && doneCnt == 0; k++) begin
            hreadyin = !((k >= stallK && k < stallK + stallLen) || (k == errK));
            hresp    = (errK > 0) && (k == errK || k == errK + 1);
            tick();
        end
        hreadyin = 1'b1;
        hresp    = 1'b0;
        checkOutput("done_once", 64'(doneCnt), 64'd1);
    endtask

    logic [31:0] expA[$];
    logic [31:0] expD[$];

    initial begin
        busyCnt = 0;
        tHs     = -1;

        // Reset values while hresetn is held low
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_htrans", 64'(htrans), 64'(T_IDLE));
        checkOutput("rst_haddr", 64'(haddr), 64'd0);
        checkOutput("rst_hwdata", 64'(hwdata), 64'd0);
        checkOutput("rst_cmd_ready", 64'(cmdReady), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_rd_valid", 64'(rdValid), 64'd0);
        hresetn = 1'b1;
        @(negedge clk);
        checkOutput("ready_before_edge", 64'(cmdReady), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("ready_after_edge", 64'(cmdReady), 64'd1);

        // SINGLE read, byte size, fixed read data
        useFixed = 1'b1;
        fixedRd  = 32'h0000_FFFF;
        applyStimulus(1'b0, 32'h8000_00A2, 3'b000, 3'd0, 0, 0, 0);
        checkOutput("single_nonseq", 64'(snapTrans[1]), 64'(T_NONSEQ));
        checkOutput("single_haddr", 64'(snapAddr[1]), 64'h8000_00A2);
        checkOutput("single_idle_after", 64'(snapTrans[2]), 64'(T_IDLE));
        checkOutput("single_rd_cnt", 64'(rdLog.size()), 64'd1);
        checkOutput("single_rd_data", 64'(rdLog[0]), 64'h0000_FFFF);
        checkOutput("single_rd_time", 64'(tFirstRd - tHs), 64'd3);
        checkOutput("single_done_time", 64'(tDone - tHs), 64'd3);
        checkOutput("single_no_err", 64'(errPulses), 64'd0);
        useFixed = 1'b0;

        // INCR4 write, word size
        wrBase = 32'hA300_1111;
        applyStimulus(1'b1, 32'h8000_00C0, 3'b011, 3'd2, 0, 0, 0);
        expA = '{32'h8000_00C0, 32'h8000_00C4, 32'h8000_00C8, 32'h8000_00CC};
        checkOutput("incr4_addr_cnt", 64'(addrLog.size()), 64'd4);
        checkOutput("incr4_wd_cnt", 64'(wdLog.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("incr4_addr%0d", i), 64'(addrLog[i]), 64'(expA[i]));
            checkOutput($sformatf("incr4_wd%0d", i), 64'(wdLog[i]), 64'(32'hA300_1111 + 32'(i)));
        end
        checkOutput("incr4_trans0", 64'(transLog[0]), 64'(T_NONSEQ));
        checkOutput("incr4_trans1", 64'(transLog[1]), 64'(T_SEQ));
        checkOutput("incr4_wr_req", 64'(wrReqCnt), 64'd4);
        checkOutput("incr4_done_time", 64'(tDone - tHs), 64'd6);

        // WRAP4 read, word size, wraps inside a 16-byte block
        applyStimulus(1'b0, 32'h8000_0038, 3'b010, 3'd2, 0, 0, 0);
        expA = '{32'h8000_0038, 32'h8000_003C, 32'h8000_0030, 32'h8000_0034};
        expD = '{32'hDA5A_0038, 32'hDA5A_003C, 32'hDA5A_0030, 32'hDA5A_0034};
        checkOutput("wrap4_rd_cnt", 64'(rdLog.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("wrap4_addr%0d", i), 64'(addrLog[i]), 64'(expA[i]));
            checkOutput($sformatf("wrap4_rd%0d", i), 64'(rdLog[i]), 64'(expD[i]));
        end

        // WRAP8 read, halfword size, starts near the top of its 16-byte block
        applyStimulus(1'b0, 32'h0000_100E, 3'b100, 3'd1, 0, 0, 0);
        expA = '{32'h100E, 32'h1000, 32'h1002, 32'h1004, 32'h1006, 32'h1008, 32'h100A, 32'h100C};
        checkOutput("wrap8_addr_cnt", 64'(addrLog.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("wrap8_addr%0d", i), 64'(addrLog[i]), 64'(expA[i]));
        end

        // INCR8 write with a 3-cycle wait state on beat 3
        wrBase = 32'h5500_0000;
        applyStimulus(1'b1, 32'h0000_2000, 3'b101, 3'd2, 3, 3, 0);
        checkOutput("stall_addr_cnt", 64'(addrLog.size()), 64'd8);
        checkOutput("stall_wd_cnt", 64'(wdLog.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("stall_addr%0d", i), 64'(addrLog[i]), 64'(32'h2000 + 32'(4 * i)));
            checkOutput($sformatf("stall_wd%0d", i), 64'(wdLog[i]), 64'(32'h5500_0000 + 32'(i)));
        end
        for (int k = 3; k <= 6; k++) begin
            checkOutput($sformatf("stall_haddr_k%0d", k), 64'(snapAddr[k]), 64'h2008);
            checkOutput($sformatf("stall_htrans_k%0d", k), 64'(snapTrans[k]), 64'(T_SEQ));
            checkOutput($sformatf("stall_hwdata_k%0d", k), 64'(snapWd[k]), 64'h5500_0001);
        end
        checkOutput("stall_wr_req", 64'(wrReqCnt), 64'd8);
        checkOutput("stall_done_time", 64'(tDone - tHs), 64'd13);

        // INCR4 read with an ERROR response on beat 2
        applyStimulus(1'b0, 32'h0000_3000, 3'b011, 3'd2, 0, 0, 3);
        checkOutput("err_trans_k3", 64'(snapTrans[3]), 64'(T_SEQ));
        checkOutput("err_trans_k4", 64'(snapTrans[4]), 64'(T_IDLE));
        checkOutput("err_addr_cnt", 64'(addrLog.size()), 64'd2);
        checkOutput("err_rd_cnt", 64'(rdLog.size()), 64'd2);
        checkOutput("err_rd0", 64'(rdLog[0]), 64'h5A5A_3000);
        checkOutput("err_rd1", 64'(rdLog[1]), 64'h5A5A_3004);
        checkOutput("err_with_done", 64'(errPulses), 64'd1);
        checkOutput("err_done_time", 64'(tDone - tHs), 64'd5);
`ifdef AHB_MASTER_STATS_EN
        checkOutput("err_cnt_stat", 64'(errCnt), 64'd1);
`endif

        // Illegal size for a 32-bit bus completes at once with an error
        applyStimulus(1'b0, 32'h0000_4000, 3'b000, 3'd3, 0, 0, 0);
        checkOutput("badsize_err", 64'(errPulses), 64'd1);
        checkOutput("badsize_done_time", 64'(tDone - tHs), 64'd1);
        checkOutput("badsize_no_xfer", 64'(addrLog.size()), 64'd0);

        // Reset asserted during beat 2 of an INCR16 read
        issueCmd(1'b0, 32'h0000_5000, 3'b111, 3'd2);
        tick();
        checkOutput("rst16_beat2_addr", 64'(haddr), 64'h5004);
        hresetn = 1'b0;
        #1;
        checkOutput("rst16_htrans", 64'(htrans), 64'(T_IDLE));
        checkOutput("rst16_haddr", 64'(haddr), 64'd0);
        checkOutput("rst16_cmd_ready", 64'(cmdReady), 64'd0);
        checkOutput("rst16_rd_valid", 64'(rdValid), 64'd0);
        tick();
        tick();
        hresetn = 1'b1;
        @(negedge clk);
        checkOutput("rst16_ready_before_edge", 64'(cmdReady), 64'd0);
        tick();
        checkOutput("rst16_ready_after_edge", 64'(cmdReady), 64'd1);
        checkOutput("rst16_no_done", 64'(doneCnt), 64'd0);

        checkOutput("never_busy", 64'(busyCnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
